// File: rtl/frame_buffer_sequencer.sv
// frame_buffer_sequencer
// Custom-instruction controller for a ring of camera frame buffers in SDRAM.
// The camera always writes one buffer while the CPU may hold another; each
// new-screen pulse publishes the finished frame as READY (latest frame wins)
// and hands the camera the next buffer to fill.

module frame_buffer_sequencer #(
   parameter logic [7:0] customInstructionId = 8'd0,
   parameter int         nrOfBuffers         = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ciStart,
   input  logic        ciCke,
   input  logic [7:0]  ciN,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic [31:0] ciResult,
   output logic        ciDone,
   input  logic        newScreen,
   output logic [31:0] frameBufferBase,
   output logic        grabberRun,
   output logic        frameReady
);

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      WRITING = 2'd1,
      READY   = 2'd2,
      CPU     = 2'd3
   } bufState_t;

   typedef enum logic [2:0] {
      CMD_BASE     = 3'd0,
      CMD_STRIDE   = 3'd1,
      CMD_RUN      = 3'd2,
      CMD_ACQUIRE  = 3'd3,
      CMD_RELEASE  = 3'd4,
      CMD_STATUS   = 3'd5,
      CMD_STATES   = 3'd6,
      CMD_BASE_OUT = 3'd7
   } ciCmd_t;

   bufState_t   state_q [4];
   bufState_t   state_d [4];
   logic [31:0] base_q, base_d;
   logic [31:0] stride_q, stride_d;
   logic        run_q, run_d;
   logic [15:0] completed_q, completed_d;
   logic [15:0] dropped_q, dropped_d;
   logic [1:0]  nextIdx_q, nextIdx_d;
   logic [31:0] frameBufferBase_q;
   logic        frameReady_q;

   logic        ownCi;
   ciCmd_t      cmd;
   logic        hasWriting, hasReady, hasCpu;
   logic [1:0]  writingIdx, readyIdx, cpuIdx;
   logic        ciRunClear;
   logic        freeFound, readyFoundNext, anyReadyNext;
   logic [1:0]  freeIdx, readyIdxNext, writingIdxNext;
   logic        unusedCiBits;

   // Buffer address base + idx*stride built from shifted adds; wraps at 32 bits.
   function automatic logic [31:0] bufferAddress(input logic [1:0]  idx,
                                                 input logic [31:0] baseAddr,
                                                 input logic [31:0] strideBytes);
      logic [31:0] addr;
      addr = baseAddr;
      if (idx[0]) addr = addr + strideBytes;
      if (idx[1]) addr = addr + {strideBytes[30:0], 1'b0};
      return addr;
   endfunction

   assign ownCi        = ciStart & ciCke & (ciN == customInstructionId);
   assign cmd          = ciCmd_t'(ciValueA[2:0]);
   assign unusedCiBits = ^{ciValueA[31:3], ciValueB[1]};

   // Locate the single buffer (if any) currently in each non-free state.
   always_comb begin
      hasWriting = 1'b0;
      hasReady   = 1'b0;
      hasCpu     = 1'b0;
      writingIdx = 2'd0;
      readyIdx   = 2'd0;
      cpuIdx     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (i < nrOfBuffers) begin
            case (state_q[i])
               WRITING: begin hasWriting = 1'b1; writingIdx = 2'(i); end
               READY:   begin hasReady   = 1'b1; readyIdx   = 2'(i); end
               CPU:     begin hasCpu     = 1'b1; cpuIdx     = 2'(i); end
               default: ;
            endcase
         end
      end
   end

   // Next state: apply the CI first (it sees the pre-edge state), then the
   // frame rotation on top of it, so an acquire shields its buffer and a
   // release frees its buffer within the same update. A run-clear wins over
   // a coincident new-screen pulse.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      stride_d    = stride_q;
      run_d       = run_q;
      completed_d = completed_q;
      dropped_d   = dropped_q;
      ciRunClear  = 1'b0;
      if (ownCi) begin
         case (cmd)
            CMD_BASE:    if (!run_q) base_d = {ciValueB[31:2], 2'b00};
            CMD_STRIDE:  if (!run_q) stride_d = {ciValueB[31:2], 2'b00};
            CMD_RUN: begin
               run_d = ciValueB[0];
               if (!ciValueB[0]) begin
                  ciRunClear = 1'b1;
                  if (hasWriting) state_d[writingIdx] = FREE;
               end
            end
            CMD_ACQUIRE: if (hasReady && !hasCpu) state_d[readyIdx] = CPU;
            CMD_RELEASE: if (hasCpu) state_d[cpuIdx] = FREE;
            default: ;
         endcase
      end
      if (newScreen && run_q && !ciRunClear) begin
         if (state_d[nextIdx_q] == WRITING || state_d[nextIdx_q] == CPU) begin
            if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
         end else begin
            if (hasWriting) begin
               for (int i = 0; i < 4; i++) begin
                  if (state_d[i] == READY) state_d[i] = FREE;
               end
               state_d[writingIdx] = READY;
               if (completed_q != 16'hFFFF) completed_d = completed_q + 16'd1;
            end
            state_d[nextIdx_q] = WRITING;
         end
      end
   end

   // Pick the buffer the camera fills next: lowest FREE, else the READY one
   // (it gets superseded by the next frame anyway), else keep overwriting
   // the WRITING one and count the lost frame.
   always_comb begin
      freeFound      = 1'b0;
      readyFoundNext = 1'b0;
      freeIdx        = 2'd0;
      readyIdxNext   = 2'd0;
      writingIdxNext = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (i < nrOfBuffers) begin
            if (state_d[i] == FREE)    begin freeFound = 1'b1; freeIdx = 2'(i); end
            if (state_d[i] == READY)   begin readyFoundNext = 1'b1; readyIdxNext = 2'(i); end
            if (state_d[i] == WRITING) writingIdxNext = 2'(i);
         end
      end
      anyReadyNext = readyFoundNext;
      if (freeFound)           nextIdx_d = freeIdx;
      else if (readyFoundNext) nextIdx_d = readyIdxNext;
      else                     nextIdx_d = writingIdxNext;
   end

   // State register; camera-facing outputs are registered from next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) state_q[i] <= FREE;
         base_q            <= '0;
         stride_q          <= '0;
         run_q             <= 1'b0;
         completed_q       <= '0;
         dropped_q         <= '0;
         nextIdx_q         <= '0;
         frameBufferBase_q <= '0;
         frameReady_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         base_q            <= base_d;
         stride_q          <= stride_d;
         run_q             <= run_d;
         completed_q       <= completed_d;
         dropped_q         <= dropped_d;
         nextIdx_q         <= nextIdx_d;
         frameBufferBase_q <= bufferAddress(nextIdx_d, base_d, stride_d);
         frameReady_q      <= anyReadyNext;
      end
   end

   // CI result path: combinational answer from the pre-edge state.
   always_comb begin
      ciDone   = ownCi;
      ciResult = 32'd0;
      if (ownCi) begin
         case (cmd)
            CMD_ACQUIRE:  if (hasReady && !hasCpu)
                             ciResult = bufferAddress(readyIdx, base_q, stride_q) | 32'd1;
            CMD_STATUS:   ciResult = {dropped_q, completed_q};
            CMD_STATES:   ciResult = {24'd0, state_q[3], state_q[2], state_q[1], state_q[0]};
            CMD_BASE_OUT: ciResult = frameBufferBase_q;
            default:      ciResult = 32'd0;
         endcase
      end
   end

   assign frameBufferBase = frameBufferBase_q;
   assign grabberRun      = run_q;
   assign frameReady      = frameReady_q;

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Testbench for frame_buffer_sequencer: two instances (3-buffer ring on CI 0,
// 2-buffer ring on CI 5) driven by shared stimulus, checked by a scoreboard
// against a reference model that tracks which buffer is writing/ready/held.

module tb_frame_buffer_sequencer;

   localparam int         N0  = 3;
   localparam int         N1  = 2;
   localparam logic [7:0] ID0 = 8'd0;
   localparam logic [7:0] ID1 = 8'd5;

   logic        clock = 1'b0;
   logic        reset;
   logic        ciStart, ciCke, newScreen;
   logic [7:0]  ciN;
   logic [31:0] ciValueA, ciValueB;
   logic [31:0] ciResultArr [2];
   logic [31:0] fbbArr [2];
   logic        ciDoneArr [2];
   logic        runArr [2];
   logic        readyArr [2];

   int checks = 0;
   int errors = 0;
   bit finishReq = 0;
   bit finishAck = 0;

   logic [31:0] expQ0 [$];
   logic [31:0] expQ1 [$];

   // Reference model: index of the buffer in each role, -1 when none.
   int          writingBuf [2];
   int          readyBuf [2];
   int          cpuBuf [2];
   logic [31:0] mBase [2];
   logic [31:0] mStride [2];
   bit          mRun [2];
   int          mCompleted [2];
   int          mDropped [2];

   always #5 clock = ~clock;

   frame_buffer_sequencer #(.customInstructionId(ID0), .nrOfBuffers(N0)) u0 (
      .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
      .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResultArr[0]),
      .ciDone(ciDoneArr[0]), .newScreen(newScreen), .frameBufferBase(fbbArr[0]),
      .grabberRun(runArr[0]), .frameReady(readyArr[0]));

   frame_buffer_sequencer #(.customInstructionId(ID1), .nrOfBuffers(N1)) u1 (
      .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
      .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResultArr[1]),
      .ciDone(ciDoneArr[1]), .newScreen(newScreen), .frameBufferBase(fbbArr[1]),
      .grabberRun(runArr[1]), .frameReady(readyArr[1]));

   function automatic int nBuf(int k);
      return (k == 0) ? N0 : N1;
   endfunction

   function automatic logic [7:0] ciId(int k);
      return (k == 0) ? ID0 : ID1;
   endfunction

   function automatic logic [31:0] addrOf(int k, int idx);
      return mBase[k] + 32'(idx) * mStride[k];
   endfunction

   // Buffer the camera gets next: lowest free one, else the ready one,
   // else the one being written (frame dropped).
   function automatic int nextTarget(int k);
      for (int i = 0; i < nBuf(k); i++) begin
         if (i != writingBuf[k] && i != readyBuf[k] && i != cpuBuf[k]) return i;
      end
      if (readyBuf[k] >= 0) return readyBuf[k];
      return writingBuf[k];
   endfunction

   function automatic int stateCode(int k, int i);
      if (i == writingBuf[k]) return 1;
      if (i == readyBuf[k])   return 2;
      if (i == cpuBuf[k])     return 3;
      return 0;
   endfunction

   function automatic logic [31:0] expResult(int k, logic [2:0] cmd);
      logic [31:0] r;
      r = 32'd0;
      case (cmd)
         3'd3: if (readyBuf[k] >= 0 && cpuBuf[k] < 0) r = addrOf(k, readyBuf[k]) | 32'd1;
         3'd5: r = {16'(mDropped[k]), 16'(mCompleted[k])};
         3'd6: for (int i = 0; i < 4; i++) r = r | (32'(stateCode(k, i)) << (2 * i));
         3'd7: r = addrOf(k, nextTarget(k));
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic void modelReset(int k);
      writingBuf[k] = -1;
      readyBuf[k]   = -1;
      cpuBuf[k]     = -1;
      mBase[k]      = 32'd0;
      mStride[k]    = 32'd0;
      mRun[k]       = 1'b0;
      mCompleted[k] = 0;
      mDropped[k]   = 0;
   endfunction

   function automatic void modelEdge(int k, bit own, logic [2:0] cmd, logic [31:0] b, bit ns);
      int  target;
      bit  runBefore;
      bit  runClear;
      target    = nextTarget(k);
      runBefore = mRun[k];
      runClear  = 1'b0;
      if (own) begin
         case (cmd)
            3'd0: if (!runBefore) mBase[k] = b & ~32'd3;
            3'd1: if (!runBefore) mStride[k] = b & ~32'd3;
            3'd2: begin
               mRun[k] = b[0];
               if (!b[0]) begin
                  runClear      = 1'b1;
                  writingBuf[k] = -1;
               end
            end
            3'd3: if (readyBuf[k] >= 0 && cpuBuf[k] < 0) begin
               cpuBuf[k]   = readyBuf[k];
               readyBuf[k] = -1;
            end
            3'd4: cpuBuf[k] = -1;
            default: ;
         endcase
      end
      if (ns && runBefore && !runClear) begin
         if (target == writingBuf[k] || target == cpuBuf[k]) begin
            if (mDropped[k] < 65535) mDropped[k]++;
         end else begin
            if (writingBuf[k] >= 0) begin
               readyBuf[k] = writingBuf[k];
               if (mCompleted[k] < 65535) mCompleted[k]++;
            end else if (target == readyBuf[k]) begin
               readyBuf[k] = -1;
            end
            writingBuf[k] = target;
         end
      end
   endfunction

   task automatic checkOutput(input int k, input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL u%0d %s: got 0x%08h, required 0x%08h at %0t", k, name, actual, required, $time);
      end
   endtask

   // Monitor: pops the expected CI result whenever an instance answers and
   // compares the registered outputs against the model every cycle.
   always @(negedge clock) begin
      logic [31:0] expVal;
      bit          have;
      for (int k = 0; k < 2; k++) begin
         if (ciDoneArr[k]) begin
            have   = 1'b0;
            expVal = 32'd0;
            if (k == 0 && expQ0.size() > 0) begin expVal = expQ0.pop_front(); have = 1'b1; end
            if (k == 1 && expQ1.size() > 0) begin expVal = expQ1.pop_front(); have = 1'b1; end
            if (have) checkOutput(k, "ciResult", ciResultArr[k], expVal);
            else begin
               checks++;
               errors++;
               $display("[TB] FAIL u%0d unexpectedDone: ciDone=1, required 0 (no CI pending) at %0t", k, $time);
            end
         end else begin
            checkOutput(k, "ciResultIdle", ciResultArr[k], 32'd0);
         end
         checkOutput(k, "frameBufferBase", fbbArr[k], addrOf(k, nextTarget(k)));
         checkOutput(k, "grabberRun", {31'd0, runArr[k]}, {31'd0, mRun[k]});
         checkOutput(k, "frameReady", {31'd0, readyArr[k]}, {31'd0, (readyBuf[k] >= 0)});
      end
      if (finishReq && !finishAck) begin
         checkOutput(0, "pendingResults", 32'(expQ0.size()), 32'd0);
         checkOutput(1, "pendingResults", 32'(expQ1.size()), 32'd0);
         finishAck = 1'b1;
      end
   end

   // One cycle of stimulus, issued just after a rising edge.
   task automatic applyStimulus(input bit start, input bit cke, input logic [7:0] nSel,
                                input logic [2:0] cmd, input logic [31:0] b, input bit ns);
      bit own [2];
      ciStart       = start;
      ciCke         = cke;
      ciN           = nSel;
      ciValueA      = $urandom();
      ciValueA[2:0] = cmd;
      ciValueB      = b;
      newScreen     = ns;
      for (int k = 0; k < 2; k++) begin
         own[k] = start && cke && (nSel == ciId(k));
         if (own[k]) begin
            if (k == 0) expQ0.push_back(expResult(k, cmd));
            else        expQ1.push_back(expResult(k, cmd));
         end
      end
      @(posedge clock);
      for (int k = 0; k < 2; k++) modelEdge(k, own[k], cmd, b, ns);
      #1;
      ciStart   = 1'b0;
      ciCke     = 1'b0;
      newScreen = 1'b0;
   endtask

   task automatic ci(input logic [7:0] id, input logic [2:0] cmd, input logic [31:0] b, input bit ns);
      applyStimulus(1'b1, 1'b1, id, cmd, b, ns);
   endtask

   task automatic idle(input bit ns);
      applyStimulus(1'b0, 1'b0, 8'd0, 3'd0, 32'd0, ns);
   endtask

   // Reset asserted mid-cycle to exercise the asynchronous path.
   task automatic resetPulse();
      #2;
      reset = 1'b1;
      modelReset(0);
      modelReset(1);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [2:0]  cmd;
      logic [31:0] b;
      logic [7:0]  nSel;
      reset     = 1'b1;
      ciStart   = 1'b0;
      ciCke     = 1'b0;
      ciN       = 8'd0;
      ciValueA  = 32'd0;
      ciValueB  = 32'd0;
      newScreen = 1'b0;
      modelReset(0);
      modelReset(1);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Configure both rings and start the camera.
      ci(ID0, 3'd6, 32'd0, 1'b0);
      foreach (expQ0[i]) ;
      ci(ID0, 3'd0, 32'h0000_1000, 1'b0);
      ci(ID0, 3'd1, 32'h0004_B000, 1'b0);
      ci(ID1, 3'd0, 32'h0000_1003, 1'b0);
      ci(ID1, 3'd1, 32'h0004_B000, 1'b0);
      ci(ID0, 3'd2, 32'd1, 1'b0);
      ci(ID1, 3'd2, 32'd1, 1'b0);
      ci(ID0, 3'd7, 32'd0, 1'b0);
      ci(ID0, 3'd6, 32'd0, 1'b0);

      // Three frames, then acquire the latest one.
      repeat (3) idle(1'b1);
      ci(ID0, 3'd5, 32'd0, 1'b0);
      ci(ID0, 3'd3, 32'd0, 1'b0);
      ci(ID0, 3'd6, 32'd0, 1'b0);
      ci(ID1, 3'd3, 32'd0, 1'b0);
      repeat (2) idle(1'b1);
      ci(ID1, 3'd5, 32'd0, 1'b0);
      ci(ID1, 3'd6, 32'd0, 1'b0);
      ci(ID1, 3'd7, 32'd0, 1'b0);

      // Release, build a new frame, acquire coincident with a new screen.
      ci(ID0, 3'd4, 32'd0, 1'b0);
      ci(ID1, 3'd4, 32'd0, 1'b1);
      idle(1'b1);
      ci(ID0, 3'd3, 32'd0, 1'b1);
      ci(ID0, 3'd6, 32'd0, 1'b0);
      ci(ID0, 3'd3, 32'd0, 1'b0);
      ci(ID0, 3'd4, 32'd0, 1'b0);
      ci(ID0, 3'd3, 32'd0, 1'b0);
      ci(ID0, 3'd3, 32'd0, 1'b0);

      // Base write ignored while running, run-clear mid-frame, restart.
      ci(ID0, 3'd0, 32'h0002_0000, 1'b0);
      ci(ID0, 3'd7, 32'd0, 1'b0);
      ci(ID0, 3'd2, 32'd0, 1'b1);
      ci(ID0, 3'd6, 32'd0, 1'b0);
      ci(ID0, 3'd2, 32'd1, 1'b1);
      idle(1'b1);
      ci(ID0, 3'd5, 32'd0, 1'b0);
      resetPulse();
      ci(ID0, 3'd5, 32'd0, 1'b0);

      // Randomized traffic.
      for (int step = 0; step < 2500; step++) begin
         case ($urandom_range(0, 4))
            0, 1:    nSel = ID0;
            2, 3:    nSel = ID1;
            default: nSel = 8'($urandom());
         endcase
         cmd = 3'($urandom_range(0, 7));
         b   = $urandom();
         if (cmd == 3'd2) b[0] = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 299) == 0) resetPulse();
         else applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9, nSel, cmd, b,
                            $urandom_range(0, 9) < 3);
      end

      idle(1'b0);
      finishReq = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      if (!finishAck) begin
         $display("[TB] FAIL finishHandshake: monitor did not acknowledge, required acknowledge");
         $fatal(1, "[TB] monitor stalled");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
